// File: rtl/uart_tx_fifo_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_pkg
//
// Shared definitions for the UART transmit buffer slice: character bus
// width, default FIFO depth / pacing gap / drop counter width, and a small
// helper that classifies a FIFO cycle into one of four operations so the
// occupancy update reads as a plain case statement.
//
// The sync_fifo sub-module imports this package. It is written to be reused
// later as the MMIO store buffer, so nothing here is UART-specific apart
// from the defaults.
// ---------------------------------------------------------------------------
package uart_tx_fifo_pkg;

    // Character bus: a0[7:0] from the putch path
    localparam int UART_CH_W       = 8;

    // Defaults for the top-level parameters
    localparam int UART_FIFO_DEPTH = 16;
    localparam int UART_GAP_CYCLES = 4;
    localparam int UART_DROP_W     = 16;

    typedef logic [UART_CH_W-1:0] uart_ch_t;

    // What the FIFO does on a given edge. Encoding is {pop, push} so the
    // helper below is a straight cast.
    typedef enum logic [1:0] {
        FIFO_OP_IDLE = 2'b00,
        FIFO_OP_PUSH = 2'b01,
        FIFO_OP_POP  = 2'b10,
        FIFO_OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e fifo_op(input logic push, input logic pop);
        return fifo_op_e'({pop, push});
    endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//
// Single-clock FIFO with synchronous active-high reset and a synchronous
// flush. Storage is a plain register array. Pointers are log2(DEPTH) bits
// and wrap naturally because DEPTH is a power of two; occupancy is tracked
// in a separate count register, which alone decides full/empty.
//
// Ports:
//   clock  in   system clock, all state changes on posedge
//   reset  in   synchronous active-high reset (highest priority)
//   flush  in   synchronous clear of pointers and count (below reset)
//   push   in   write request; ignored while full
//   wdata  in   data written at wr_ptr on an accepted push
//   pop    in   read request; ignored while empty
//   rdata  out  entry at rd_ptr, combinational (head of queue)
//   full   out  count == DEPTH
//   empty  out  count == 0
//   count  out  current occupancy, $clog2(DEPTH)+1 bits
// ---------------------------------------------------------------------------
module sync_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH = UART_FIFO_DEPTH,
    parameter int WIDTH = UART_CH_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    logic push_ok;
    logic pop_ok;

    // Requests are qualified here so a caller can never corrupt the
    // occupancy: a push while full or a pop while empty is a no-op.
    assign full    = (count == CNT_DEPTH);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage has no reset; stale contents are unreachable once the
    // pointers and count are cleared. Writes are blocked during reset and
    // flush so the array only changes on an accepted push.
    always_ff @(posedge clock) begin
        if (!reset && !flush && push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy update. A simultaneous push and pop advances
    // both pointers and leaves the count alone.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            case (fifo_op(push_ok, pop_ok))
                FIFO_OP_PUSH: begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                    count  <= count + CNT_ONE;
                end
                FIFO_OP_POP: begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                    count  <= count - CNT_ONE;
                end
                FIFO_OP_BOTH: begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//
// Buffers characters from the core's putch path and drains them onto the
// SimTop UART output pins as single-cycle pulses, separated by a fixed idle
// gap so the host-side console model is never flooded. Writes that arrive
// while the buffer is full are dropped and counted for debug.
//
// Ports:
//   clock           in   system clock, all state changes on posedge
//   reset           in   synchronous active-high reset (highest priority)
//   wr_en           in   putch strobe, one character per asserted cycle
//   wr_ch           in   character to enqueue
//   flush           in   synchronous clear of queue and pacing state;
//                        a write in the same cycle is discarded uncounted
//   full            out  occupancy == DEPTH
//   empty           out  occupancy == 0
//   count           out  current occupancy
//   uart_out_valid  out  registered one-cycle pulse per character
//   uart_out_ch     out  registered character, meaningful while valid
//   drop_cnt        out  saturating count of writes rejected while full
// ---------------------------------------------------------------------------
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH      = UART_FIFO_DEPTH,
    parameter int GAP_CYCLES = UART_GAP_CYCLES,
    parameter int DROP_W     = UART_DROP_W
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [UART_CH_W-1:0]   wr_ch,
    input  logic                   flush,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   uart_out_valid,
    output logic [UART_CH_W-1:0]   uart_out_ch,
    output logic [DROP_W-1:0]      drop_cnt
);

    // Gap counter needs to hold GAP_CYCLES; keep at least one bit so a
    // zero gap still elaborates to a legal (always-zero) register.
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [GW-1:0]     GAP_LOAD = GW'(GAP_CYCLES);
    localparam logic [GW-1:0]     GAP_ONE  = GW'(1);
    localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);

    logic [GW-1:0] gap_cnt;
    uart_ch_t      head_ch;
    logic          push;
    logic          pop;
    logic          drop;

    // A write is accepted only if the buffer was not full before the edge.
    // A pop on the same edge does not rescue it: the slot is freed too late.
    // Flush swallows any concurrent write without counting it as a drop.
    assign push = wr_en && !full && !flush;
    assign drop = wr_en &&  full && !flush && !reset;

    // Emit the head character whenever something is queued and the idle
    // gap after the previous pulse has fully elapsed. The output register
    // only sees entries already stored, so a write can never bypass to the
    // output on the edge that stores it.
    assign pop = !empty && (gap_cnt == '0);

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (UART_CH_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .push  (push),
        .wdata (wr_ch),
        .pop   (pop),
        .rdata (head_ch),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Output register and pacing counter. Loading GAP_CYCLES on a pulse and
    // counting down to zero gives exactly GAP_CYCLES low cycles between
    // pulses while characters remain queued. The character register holds
    // its last value between pulses; only flush and reset stop pacing.
    always_ff @(posedge clock) begin
        if (reset) begin
            uart_out_valid <= 1'b0;
            uart_out_ch    <= '0;
            gap_cnt        <= '0;
        end else if (flush) begin
            uart_out_valid <= 1'b0;
            gap_cnt        <= '0;
        end else if (pop) begin
            uart_out_valid <= 1'b1;
            uart_out_ch    <= head_ch;
            gap_cnt        <= GAP_LOAD;
        end else begin
            uart_out_valid <= 1'b0;
            if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GAP_ONE;
            end
        end
    end

    // Debug drop counter. Sticks at all-ones rather than wrapping so a
    // large overflow is never mistaken for a small one. Flush leaves it
    // untouched; only reset clears it.
    always_ff @(posedge clock) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + DROP_ONE;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Drives two instances of uart_tx_fifo: one with a 4-cycle idle gap and one
// with back-to-back output. Expected characters are queued when a write is
// known to be accepted and are popped by a monitor on every output pulse.
// Directed steps check occupancy, flags, drop counts and pulse timing.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

    logic       clock;
    int         cyc;
    int         compared;
    int         mismatched;

    // Instance with GAP_CYCLES = 4
    logic       reset4, wr_en4, flush4;
    logic [7:0] wr_ch4;
    logic       full4, empty4, valid4;
    logic [4:0] count4;
    logic [7:0] ch4;
    logic [15:0] drop4;

    // Instance with GAP_CYCLES = 0
    logic       reset0, wr_en0, flush0;
    logic [7:0] wr_ch0;
    logic       full0, empty0, valid0;
    logic [4:0] count0;
    logic [7:0] ch0;
    logic [15:0] drop0;

    logic [7:0] sb4[$];
    logic [7:0] sb0[$];
    int         pulse_t4[$];
    int         pulse_t0[$];

    logic [7:0] hello [5] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};

    uart_tx_fifo #(.DEPTH(16), .GAP_CYCLES(4), .DROP_W(16)) dut_g4 (
        .clock          (clock),
        .reset          (reset4),
        .wr_en          (wr_en4),
        .wr_ch          (wr_ch4),
        .flush          (flush4),
        .full           (full4),
        .empty          (empty4),
        .count          (count4),
        .uart_out_valid (valid4),
        .uart_out_ch    (ch4),
        .drop_cnt       (drop4)
    );

    uart_tx_fifo #(.DEPTH(16), .GAP_CYCLES(0), .DROP_W(16)) dut_g0 (
        .clock          (clock),
        .reset          (reset0),
        .wr_en          (wr_en0),
        .wr_ch          (wr_ch0),
        .flush          (flush0),
        .full           (full0),
        .empty          (empty0),
        .count          (count0),
        .uart_out_valid (valid0),
        .uart_out_ch    (ch0),
        .drop_cnt       (drop0)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Cycle counter used to timestamp output pulses
    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // One comparison: counts it, and reports it if the values differ
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        wr_en4 = 1'b0;
        flush4 = 1'b0;
        wr_en0 = 1'b0;
        flush0 = 1'b0;
        repeat (n) tick();
    endtask

    // Drive one cycle of inputs into the selected instance (0: gap 4,
    // 1: gap 0), clock it in, then return the strobes to idle
    task automatic applyStimulus(input bit sel, input logic we,
                                 input logic [7:0] ch, input logic fl);
        if (sel == 1'b0) begin
            wr_en4 = we; wr_ch4 = ch; flush4 = fl;
        end else begin
            wr_en0 = we; wr_ch0 = ch; flush0 = fl;
        end
        tick();
        wr_en4 = 1'b0; flush4 = 1'b0;
        wr_en0 = 1'b0; flush0 = 1'b0;
    endtask

    // Scoreboard monitors, sampled on the falling edge
    always @(negedge clock) begin
        if (valid4 === 1'b1) begin
            pulse_t4.push_back(cyc);
            checkOutput("g4_pulse_expected", 32'(sb4.size() != 0), 32'd1);
            if (sb4.size() != 0) checkOutput("g4_out_ch", 32'(ch4), 32'(sb4.pop_front()));
        end
    end

    always @(negedge clock) begin
        if (valid0 === 1'b1) begin
            pulse_t0.push_back(cyc);
            checkOutput("g0_pulse_expected", 32'(sb0.size() != 0), 32'd1);
            if (sb0.size() != 0) checkOutput("g0_out_ch", 32'(ch0), 32'(sb0.pop_front()));
        end
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        reset4 = 1'b1; wr_en4 = 1'b0; wr_ch4 = 8'h00; flush4 = 1'b0;
        reset0 = 1'b1; wr_en0 = 1'b0; wr_ch0 = 8'h00; flush0 = 1'b0;

        // Reset state
        tick();
        tick();
        checkOutput("rst_valid", 32'(valid4), 32'd0);
        checkOutput("rst_ch", 32'(ch4), 32'h00);
        checkOutput("rst_count", 32'(count4), 32'd0);
        checkOutput("rst_empty", 32'(empty4), 32'd1);
        checkOutput("rst_full", 32'(full4), 32'd0);
        checkOutput("rst_drop", 32'(drop4), 32'd0);
        checkOutput("rst_g0_empty", 32'(empty0), 32'd1);
        reset4 = 1'b0;
        reset0 = 1'b0;

        // Single character: no bypass on the write edge, pulse next cycle
        sb4.push_back(8'h41);
        applyStimulus(1'b0, 1'b1, 8'h41, 1'b0);
        checkOutput("a_count_after_write", 32'(count4), 32'd1);
        checkOutput("a_no_bypass", 32'(valid4), 32'd0);
        idle(1);
        checkOutput("a_valid", 32'(valid4), 32'd1);
        checkOutput("a_ch", 32'(ch4), 32'h41);
        checkOutput("a_count_drained", 32'(count4), 32'd0);
        idle(1);
        checkOutput("a_single_pulse", 32'(valid4), 32'd0);
        idle(8);
        checkOutput("a_drop", 32'(drop4), 32'd0);

        // HELLO: five pulses, 4 low cycles apart
        pulse_t4.delete();
        for (int i = 0; i < 5; i++) begin
            sb4.push_back(hello[i]);
            applyStimulus(1'b0, 1'b1, hello[i], 1'b0);
        end
        idle(30);
        checkOutput("hello_pulses", 32'(pulse_t4.size()), 32'd5);
        if (pulse_t4.size() == 5) begin
            for (int i = 0; i < 4; i++)
                checkOutput("hello_spacing", 32'(pulse_t4[i+1] - pulse_t4[i]), 32'd5);
            checkOutput("hello_span", 32'(pulse_t4[4] - pulse_t4[0]), 32'd20);
        end
        checkOutput("hello_sb_drained", 32'(sb4.size()), 32'd0);

        // Overflow: 24 back-to-back writes. Pops at burst edges 2,7,12,17,22
        // leave the queue full at edge 20; writes 21, 22 (despite the pop
        // on that edge) and 24 are rejected.
        pulse_t4.delete();
        for (int i = 0; i < 24; i++) begin
            if (!((i + 1) == 21 || (i + 1) == 22 || (i + 1) == 24))
                sb4.push_back(8'(8'h61 + i));
            applyStimulus(1'b0, 1'b1, 8'(8'h61 + i), 1'b0);
            if ((i + 1) == 20) begin
                checkOutput("ovf_full_at_16", 32'(full4), 32'd1);
                checkOutput("ovf_count_16", 32'(count4), 32'd16);
            end
            if ((i + 1) == 22) begin
                checkOutput("ovf_drop_with_pop", 32'(drop4), 32'd2);
                checkOutput("ovf_count_after_pop", 32'(count4), 32'd15);
            end
        end
        checkOutput("ovf_drop_total", 32'(drop4), 32'd3);
        idle(120);
        checkOutput("ovf_pulses", 32'(pulse_t4.size()), 32'd21);
        checkOutput("ovf_sb_drained", 32'(sb4.size()), 32'd0);
        checkOutput("ovf_empty", 32'(empty4), 32'd1);

        // Zero gap: 16 characters give 16 consecutive pulses, then a second
        // burst exercises pointer wrap
        pulse_t0.delete();
        for (int i = 0; i < 16; i++) begin
            sb0.push_back(8'(8'h30 + i));
            applyStimulus(1'b1, 1'b1, 8'(8'h30 + i), 1'b0);
            if (i == 7) begin
                checkOutput("g0_count_steady", 32'(count0), 32'd1);
                checkOutput("g0_not_full", 32'(full0), 32'd0);
            end
        end
        idle(5);
        checkOutput("g0_pulses", 32'(pulse_t0.size()), 32'd16);
        if (pulse_t0.size() == 16)
            checkOutput("g0_consecutive", 32'(pulse_t0[15] - pulse_t0[0]), 32'd15);
        checkOutput("g0_empty", 32'(empty0), 32'd1);
        for (int i = 0; i < 16; i++) begin
            sb0.push_back(8'(8'hA0 + i));
            applyStimulus(1'b1, 1'b1, 8'(8'hA0 + i), 1'b0);
        end
        idle(5);
        checkOutput("g0_wrap_pulses", 32'(pulse_t0.size()), 32'd32);
        checkOutput("g0_wrap_sb", 32'(sb0.size()), 32'd0);
        checkOutput("g0_drop", 32'(drop0), 32'd0);

        // Flush in the second output gap, with a concurrent write
        idle(10);
        pulse_t4.delete();
        for (int i = 0; i < 8; i++) begin
            sb4.push_back(8'(8'h31 + i));
            applyStimulus(1'b0, 1'b1, 8'(8'h31 + i), 1'b0);
        end
        checkOutput("fl_pulses_before", 32'(pulse_t4.size()), 32'd2);
        sb4.delete();
        applyStimulus(1'b0, 1'b1, 8'h7A, 1'b1);
        checkOutput("fl_count", 32'(count4), 32'd0);
        checkOutput("fl_empty", 32'(empty4), 32'd1);
        checkOutput("fl_valid", 32'(valid4), 32'd0);
        checkOutput("fl_drop_kept", 32'(drop4), 32'd3);
        idle(10);
        checkOutput("fl_no_more_pulses", 32'(pulse_t4.size()), 32'd2);
        sb4.push_back(8'h5A);
        applyStimulus(1'b0, 1'b1, 8'h5A, 1'b0);
        checkOutput("fl_next_count", 32'(count4), 32'd1);
        idle(1);
        checkOutput("fl_next_valid", 32'(valid4), 32'd1);
        checkOutput("fl_next_ch", 32'(ch4), 32'h5A);
        idle(3);

        // Reset in the middle of a drain
        idle(10);
        pulse_t4.delete();
        for (int i = 0; i < 8; i++) begin
            sb4.push_back(8'(8'h61 + i));
            applyStimulus(1'b0, 1'b1, 8'(8'h61 + i), 1'b0);
        end
        checkOutput("mr_pulses_before", 32'(pulse_t4.size()), 32'd2);
        sb4.delete();
        reset4 = 1'b1;
        idle(1);
        checkOutput("mr_valid", 32'(valid4), 32'd0);
        checkOutput("mr_count", 32'(count4), 32'd0);
        checkOutput("mr_drop", 32'(drop4), 32'd0);
        checkOutput("mr_ch", 32'(ch4), 32'h00);
        reset4 = 1'b0;
        idle(30);
        checkOutput("mr_no_stale", 32'(pulse_t4.size()), 32'd2);
        sb4.push_back(8'h51);
        applyStimulus(1'b0, 1'b1, 8'h51, 1'b0);
        idle(1);
        checkOutput("mr_next_valid", 32'(valid4), 32'd1);
        checkOutput("mr_next_ch", 32'(ch4), 32'h51);
        idle(3);

        checkOutput("end_sb4", 32'(sb4.size()), 32'd0);
        checkOutput("end_sb0", 32'(sb0.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
